// File: rtl/pci_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pci_pkg
//  Purpose  : Shared definitions for the PCI DMA target: state encoding,
//             the accepted PCI memory command codes and the default retry
//             timeout, plus a helper that recognises an accepted command.
//  Revision : 1.0 - initial release
// ============================================================================
package pci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DECODE     = 3'd1,
        ST_BUSY       = 3'd2,
        ST_WAIT_ACK   = 3'd3,
        ST_DATA       = 3'd4,
        ST_RETRY      = 3'd5,
        ST_DISCONNECT = 3'd6,
        ST_TURN       = 3'd7
    } state_t;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    localparam int RETRY_LIMIT_DEF = 16;

    // True for the two memory commands this target answers.
    function automatic logic is_mem_cmd(input logic [3:0] cmd);
        return (cmd == CMD_MEM_READ) || (cmd == CMD_MEM_WRITE);
    endfunction

endpackage : pci_pkg
`default_nettype wire

// File: rtl/pci_dma_target.sv
`default_nettype none
// ============================================================================
//  Module   : pci_dma_target
//  Purpose  : PCI target that maps PCI memory reads/writes in a 16 MB window
//             onto single Amiga-side DMA cycles. Medium DEVSEL decode, one
//             data phase per transaction (bursts are disconnected with data),
//             target retry when the Amiga side does not acknowledge in time.
//  Ports    :
//    PCICLK, RESETn          clock, asynchronous active-low reset
//    FRAMEn, IRDYn, CBEn     PCI master controls (sampled)
//    AD_IN                   sampled PCI AD bus
//    DEVSELn/TRDYn/STOPn     PCI target responses, TGT_OEn = their enable
//    DMA_REQn/DMA_ACKn       Amiga cycle handshake
//    DMA_RW, DMA_ADDR, DMA_BEn  Amiga cycle direction/address/byte enables
//    ADLATCH, PCI_DIR, AD_ENn   AD data buffer controls
//  Revision : 1.0 - initial release
// ============================================================================
module pci_dma_target
    import pci_pkg::*;
#(
    parameter logic [7:0] WIN_BASE    = 8'h40,
    parameter int         RETRY_LIMIT = RETRY_LIMIT_DEF
) (
    input  logic        PCICLK,
    input  logic        RESETn,
    input  logic        FRAMEn,
    input  logic        IRDYn,
    input  logic [3:0]  CBEn,
    input  logic [31:0] AD_IN,
    output logic        DEVSELn,
    output logic        TRDYn,
    output logic        STOPn,
    output logic        TGT_OEn,
    output logic        DMA_REQn,
    input  logic        DMA_ACKn,
    output logic        DMA_RW,
    output logic [31:0] DMA_ADDR,
    output logic [3:0]  DMA_BEn,
    output logic        ADLATCH,
    output logic        PCI_DIR,
    output logic        AD_ENn
);

    localparam logic [4:0] RETRY_CNT = 5'(RETRY_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [4:0]  wait_cnt_q, wait_cnt_d;
    logic        devsel_n_q, devsel_n_d;
    logic        trdy_n_q, trdy_n_d;
    logic        stop_n_q, stop_n_d;
    logic        tgt_oe_n_q, tgt_oe_n_d;
    logic        dma_req_n_q, dma_req_n_d;
    logic        dma_rw_q, dma_rw_d;
    logic        adlatch_q, adlatch_d;
    logic        pci_dir_q, pci_dir_d;
    logic        ad_en_n_q, ad_en_n_d;

    logic        hit;
    logic [4:0]  wait_cnt_inc;

    // Decode works on the latched address phase; AD_IN already carries data.
    assign hit = (addr_q[31:24] == WIN_BASE) && (addr_q[1:0] == 2'b00)
               && is_mem_cmd(cmd_q);

    assign wait_cnt_inc = wait_cnt_q + 5'd1;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wait_cnt_d  = wait_cnt_q;
        devsel_n_d  = devsel_n_q;
        trdy_n_d    = trdy_n_q;
        stop_n_d    = stop_n_q;
        tgt_oe_n_d  = tgt_oe_n_q;
        dma_req_n_d = dma_req_n_q;
        dma_rw_d    = dma_rw_q;
        adlatch_d   = 1'b0;
        pci_dir_d   = pci_dir_q;
        ad_en_n_d   = ad_en_n_q;

        case (state_q)
            ST_IDLE: begin
                if (!FRAMEn) begin
                    addr_d  = AD_IN;
                    cmd_d   = CBEn;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if (hit) begin
                    devsel_n_d = 1'b0;
                    tgt_oe_n_d = 1'b0;
                    wait_cnt_d = 5'd0;
                    state_d    = ST_WAIT_ACK;
                end else begin
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (FRAMEn && IRDYn) begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_ACK: begin
                wait_cnt_d = wait_cnt_inc;
                if (FRAMEn && IRDYn) begin
                    // Master gave up: drop the Amiga request and turn around.
                    dma_req_n_d = 1'b1;
                    devsel_n_d  = 1'b1;
                    trdy_n_d    = 1'b1;
                    stop_n_d    = 1'b1;
                    pci_dir_d   = 1'b0;
                    state_d     = ST_TURN;
                end else if (!dma_req_n_q && !DMA_ACKn) begin
                    // Acknowledge beats the retry timeout on the same clock.
                    trdy_n_d    = 1'b0;
                    stop_n_d    = FRAMEn;   // FRAME# still low => burst
                    dma_req_n_d = 1'b1;
                    if (dma_rw_q) begin
                        pci_dir_d = 1'b1;
                        ad_en_n_d = 1'b0;
                    end
                    state_d = ST_DATA;
                end else if (wait_cnt_inc == RETRY_CNT) begin
                    stop_n_d    = 1'b0;
                    trdy_n_d    = 1'b1;
                    dma_req_n_d = 1'b1;
                    state_d     = ST_RETRY;
                end else if (dma_req_n_q && !IRDYn) begin
                    // First clock with IRDY# low: byte enables are valid now.
                    dma_req_n_d = 1'b0;
                    be_d        = CBEn;
                    dma_rw_d    = ~cmd_q[0];
                    adlatch_d   = cmd_q[0];
                    pci_dir_d   = 1'b0;
                    ad_en_n_d   = 1'b0;
                end
            end

            ST_DATA: begin
                if (!IRDYn) begin
                    trdy_n_d  = 1'b1;
                    pci_dir_d = 1'b0;
                    if (!stop_n_q) begin
                        state_d = ST_DISCONNECT;
                    end else begin
                        devsel_n_d = 1'b1;
                        state_d    = ST_TURN;
                    end
                end
            end

            ST_RETRY, ST_DISCONNECT: begin
                if (FRAMEn) begin
                    devsel_n_d = 1'b1;
                    trdy_n_d   = 1'b1;
                    stop_n_d   = 1'b1;
                    state_d    = ST_TURN;
                end
            end

            ST_TURN: begin
                tgt_oe_n_d = 1'b1;
                ad_en_n_d  = 1'b1;
                pci_dir_d  = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCICLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= ST_IDLE;
            cmd_q       <= 4'h0;
            addr_q      <= 32'h0;
            be_q        <= 4'hF;
            wait_cnt_q  <= 5'd0;
            devsel_n_q  <= 1'b1;
            trdy_n_q    <= 1'b1;
            stop_n_q    <= 1'b1;
            tgt_oe_n_q  <= 1'b1;
            dma_req_n_q <= 1'b1;
            dma_rw_q    <= 1'b0;
            adlatch_q   <= 1'b0;
            pci_dir_q   <= 1'b0;
            ad_en_n_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wait_cnt_q  <= wait_cnt_d;
            devsel_n_q  <= devsel_n_d;
            trdy_n_q    <= trdy_n_d;
            stop_n_q    <= stop_n_d;
            tgt_oe_n_q  <= tgt_oe_n_d;
            dma_req_n_q <= dma_req_n_d;
            dma_rw_q    <= dma_rw_d;
            adlatch_q   <= adlatch_d;
            pci_dir_q   <= pci_dir_d;
            ad_en_n_q   <= ad_en_n_d;
        end
    end

    assign DEVSELn  = devsel_n_q;
    assign TRDYn    = trdy_n_q;
    assign STOPn    = stop_n_q;
    assign TGT_OEn  = tgt_oe_n_q;
    assign DMA_REQn = dma_req_n_q;
    assign DMA_RW   = dma_rw_q;
    assign DMA_ADDR = addr_q;
    assign DMA_BEn  = be_q;
    assign ADLATCH  = adlatch_q;
    assign PCI_DIR  = pci_dir_q;
    assign AD_ENn   = ad_en_n_q;

endmodule : pci_dma_target
`default_nettype wire

// File: doc/pci_dma_target.md
PCI_DMA_TARGET -- requirements
Module: pci_dma_target

Interface
- REQ-001: Parameter WIN_BASE, default 8'h40, is the AD[31:24] value that selects the Amiga memory window for PCI-initiated DMA.
- REQ-002: Parameter RETRY_LIMIT, default 16, is the number of clocks to wait for DMA_ACKn before a target retry.
- REQ-003: PCICLK, input, 1, the single clock; all PCI and local signals are sampled on its rising edge.
- REQ-004: RESETn, input, 1, asynchronous active-low reset.
- REQ-005: FRAMEn, input, 1, PCI FRAME#.
- REQ-006: IRDYn, input, 1, PCI IRDY#.
- REQ-007: CBEn, input, 4, PCI C/BE#; carries the command in the address phase and the byte enables in the data phase.
- REQ-008: AD_IN, input, 32, PCI AD bus as sampled.
- REQ-009: DEVSELn, TRDYn and STOPn, output, 1 each, PCI target responses.
- REQ-010: TGT_OEn, output, 1, low while DEVSELn, TRDYn and STOPn are driven, including the sustained-tristate cycle.
- REQ-011: DMA_REQn, output, 1, requests an Amiga bus cycle.
- REQ-012: DMA_ACKn, input, 1, Amiga cycle complete; read data is valid when it is low.
- REQ-013: DMA_RW, output, 1; 1 means PCI read.
- REQ-014: DMA_ADDR, output, 32, latched address.
- REQ-015: DMA_BEn, output, 4, latched byte enables.
- REQ-016: ADLATCH, output, 1, a one-clock pulse that captures AD data into the buffer.
- REQ-017: PCI_DIR, output, 1; 1 drives Amiga data onto AD.
- REQ-018: AD_ENn, output, 1, AD buffer enable, active low.

Function
- REQ-019: The state machine SHALL have the states IDLE, DECODE, BUSY, WAIT_ACK, DATA, RETRY, DISCONNECT and TURN.
- REQ-020: In IDLE, when FRAMEn falls, the block SHALL capture AD_IN into DMA_ADDR and CBEn into the command register, then go to DECODE.
- REQ-021: A hit SHALL require AD_IN[31:24]==WIN_BASE, AD_IN[1:0]==2'b00 and a command of 4'b0110 (memory read) or 4'b0111 (memory write).
- REQ-022: On a miss the block SHALL go to BUSY and drive nothing until FRAMEn and IRDYn are both high, then return to IDLE.
- REQ-023: On a hit, the clock after DECODE (medium decode) SHALL assert DEVSELn low and TGT_OEn low and SHALL go to WAIT_ACK.
- REQ-024: On entry to WAIT_ACK the block SHALL latch DMA_BEn from CBEn on the first clock where IRDYn is low.
- REQ-025: In WAIT_ACK, DMA_REQn SHALL assert low once IRDYn is low, with DMA_RW = ~cmd[0].
- REQ-026: For a write, ADLATCH SHALL pulse high for one clock coincident with the DMA_REQn assertion; PCI_DIR=0 and AD_ENn=0.
- REQ-027: For a read, PCI_DIR=1 and AD_ENn=0 SHALL hold from DMA_ACKn low until the data transfer completes.
- REQ-028: When DMA_ACKn is sampled low, the next clock SHALL assert TRDYn low and DMA_REQn high, and the state SHALL go to DATA.
- REQ-029: If FRAMEn is still low in DATA (burst), STOPn SHALL assert together with TRDYn (disconnect with data), then go to DISCONNECT.
- REQ-030: In DISCONNECT, STOPn and DEVSELn SHALL hold low with TRDYn high until FRAMEn goes high.
- REQ-031: A data phase completes on the clock where TRDYn and IRDYn are both low.
- REQ-032: After a completed single transfer (FRAMEn high), or after DISCONNECT, the block SHALL go to TURN.
- REQ-033: TURN SHALL drive DEVSELn, TRDYn and STOPn high for one clock with TGT_OEn=0, then go to IDLE with TGT_OEn=1 and AD_ENn=1.
- REQ-034: A 5-bit wait counter SHALL clear on entry to WAIT_ACK and increment each clock there.
- REQ-035: When the wait counter reaches RETRY_LIMIT with DMA_ACKn still high, the block SHALL deassert DMA_REQn and go to RETRY, asserting STOPn low with TRDYn high.
- REQ-036: RETRY SHALL hold until FRAMEn is high, then go to TURN.
- REQ-037: If DMA_ACKn falls on the same clock the wait counter reaches RETRY_LIMIT, the acknowledge SHALL take priority and the state SHALL go to DATA.
- REQ-038: A DMA_ACKn low sampled outside WAIT_ACK SHALL be ignored.
- REQ-039: If FRAMEn and IRDYn are both high while the block is in WAIT_ACK (master abort), the block SHALL release DMA_REQn and go to TURN.
- REQ-040: DMA_ADDR SHALL stay stable from DECODE until IDLE.

Reset
- REQ-041: Asserting RESETn low SHALL immediately force IDLE, clear the wait counter and the command register, set DMA_ADDR=0 and DMA_BEn=4'hF, and drive DEVSELn, TRDYn, STOPn, TGT_OEn, DMA_REQn and AD_ENn high and ADLATCH, PCI_DIR and DMA_RW low.
- REQ-042: Reset mid-transaction SHALL release DMA_REQn without waiting for DMA_ACKn.
- REQ-043: Leaving reset SHALL take effect on the first PCICLK edge after RESETn is high.

Structure
- REQ-044: The state encoding, the command codes 4'b0110 and 4'b0111, and the RETRY_LIMIT default SHALL be defined in a shared package, pci_pkg.
- REQ-045: The design SHALL be a single module with no sub-modules; the wait counter is inline.

Verification
- REQ-046: Write to 32'h4000_0010 with CBEn=4'h0 and the ack after 3 clocks -> DEVSELn low at clock 2, ADLATCH one pulse, DMA_RW=0, DMA_BEn=4'h0, TRDYn low 1 clock after DMA_ACKn, then TURN, then IDLE.
- REQ-047: Read from 32'h4000_0100 -> PCI_DIR=1 and AD_ENn=0 from the acknowledge through the data phase, DMA_RW=1, no ADLATCH pulse.
- REQ-048: Address 32'h8000_0000 or command 4'b0010 -> DEVSELn stays high throughout; BUSY until the bus is idle.
- REQ-049: DMA_ACKn held high -> at clock 16 of WAIT_ACK, STOPn low, TRDYn high, DMA_REQn high; DMA_ACKn falling at clock 16 instead -> TRDYn low, no STOPn.
- REQ-050: Burst with FRAMEn held low -> STOPn and TRDYn low on the same clock, STOPn held until FRAMEn high.
- REQ-051: RESETn pulsed low during WAIT_ACK -> all outputs at their reset values asynchronously, DMA_REQn high, and a new transaction accepted afterward.
